// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment display bus read-back decoder
//
// Recovers the BCD value shown on a multiplexed common-anode display bus.
// The bus is synchronised, each selected digit's pattern must hold for
// STABLE_CYCLES synced cycles before it is decoded and captured, and a frame
// is published once every digit has been captured.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   seg_n       segment lines abcdefg (bit6=a .. bit0=g), active low, async
//   an_n        per-digit anode enables, active low, async
//   bcd_out     last complete frame, digit i in bits [4i+3:4i]
//   digit_err   per-digit invalid-pattern flags of the last frame
//   frame_valid one-cycle pulse when bcd_out/digit_err/frame_err update
//   frame_err   OR of digit_err of the last frame
//   stale       high while no capture has happened for TIMEOUT_CYCLES cycles

module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    stale
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLE   = 2'd1,
        HOLD     = 2'd2
    } state_t;

    // Two-flop synchronisers
    logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [NUM_DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d;

    // Previous-cycle copy of the synced selection, for change detection
    logic [6:0]              seg_prev_q, seg_prev_d;
    logic [IW-1:0]           idx_prev_q, idx_prev_d;

    state_t                  state_q, state_d;
    logic [SW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   derr_q, derr_d;
    logic                    fv_q, fv_d;
    logic                    ferr_q, ferr_d;
    logic [TW-1:0]           tmo_q, tmo_d;

    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic                    sel_valid;
    logic [IW-1:0]           sel_idx;
    logic                    changed;
    logic                    capture;
    logic                    emit;
    logic [4:0]              dec;

    // Returns {err, code}; all-off is a legitimate blank digit, not an error.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001111: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            7'b1111111: r = 5'h0F;
            default:    r = 5'h1E;
        endcase
        return r;
    endfunction

    // Selection: exactly one anode low; the low bit gives the digit index.
    always_comb begin
        sel_onehot = ~an_s2_q;
        sel_valid  = (sel_onehot != '0) &&
                     ((sel_onehot & (sel_onehot - 1'b1)) == '0);
        sel_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = IW'(i);
            end
        end
        changed = (sel_idx != idx_prev_q) || (seg_s2_q != seg_prev_q);
    end

    always_comb begin
        seg_s1_d   = seg_n;
        seg_s2_d   = seg_s1_q;
        an_s1_d    = an_n;
        an_s2_d    = an_s1_q;
        seg_prev_d = seg_s2_q;
        idx_prev_d = sel_idx;
    end

    // Stability FSM; cnt counts consecutive identical synced cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            WAIT_SEL: begin
                cnt_d = '0;
                if (sel_valid) begin
                    state_d = SETTLE;
                    cnt_d   = SW'(1);
                end
            end
            SETTLE: begin
                if (!sel_valid) begin
                    state_d = WAIT_SEL;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = SW'(1);
                end else if (cnt_q == SW'(STABLE_CYCLES - 1)) begin
                    // This cycle is the STABLE_CYCLES-th identical one.
                    capture = 1'b1;
                    state_d = HOLD;
                    cnt_d   = SW'(STABLE_CYCLES);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!sel_valid) begin
                    state_d = WAIT_SEL;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = SETTLE;
                    cnt_d   = SW'(1);
                end
            end
            default: begin
                state_d = WAIT_SEL;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame assembly. The clear from emit is applied before the capture
    // set, so a capture coinciding with emit counts toward the next frame.
    always_comb begin
        dec          = decode(seg_s2_q);
        emit         = &seen_q;
        seen_d       = emit ? '0 : seen_q;
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        bcd_d        = bcd_q;
        derr_d       = derr_q;
        ferr_d       = ferr_q;
        fv_d         = 1'b0;
        if (emit) begin
            bcd_d  = shadow_q;
            derr_d = shadow_err_q;
            ferr_d = |shadow_err_q;
            fv_d   = 1'b1;
        end
        if (capture) begin
            seen_d[sel_idx]                 = 1'b1;
            shadow_d[{sel_idx, 2'b00} +: 4] = dec[3:0];
            shadow_err_d[sel_idx]           = dec[4];
        end
        if (capture) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q     <= '1;
            seg_s2_q     <= '1;
            an_s1_q      <= '1;
            an_s2_q      <= '1;
            seg_prev_q   <= '1;
            idx_prev_q   <= '0;
            state_q      <= WAIT_SEL;
            cnt_q        <= '0;
            seen_q       <= '0;
            shadow_q     <= '1;
            shadow_err_q <= '0;
            bcd_q        <= '1;
            derr_q       <= '0;
            fv_q         <= 1'b0;
            ferr_q       <= 1'b0;
            tmo_q        <= '0;
        end else begin
            seg_s1_q     <= seg_s1_d;
            seg_s2_q     <= seg_s2_d;
            an_s1_q      <= an_s1_d;
            an_s2_q      <= an_s2_d;
            seg_prev_q   <= seg_prev_d;
            idx_prev_q   <= idx_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            bcd_q        <= bcd_d;
            derr_q       <= derr_d;
            fv_q         <= fv_d;
            ferr_q       <= ferr_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_err   = derr_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign stale       = (tmo_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder

module tb_seg_scan_decoder;

    localparam int N = 4;
    localparam int S = 8;
    localparam int T = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [6:0]    in_seg = 7'h7F;
    logic [N-1:0]  in_an = '1;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]  digit_err;
    logic          frame_valid;
    logic          frame_err;
    logic          stale;

    seg_scan_decoder #(
        .NUM_DIGITS(N),
        .STABLE_CYCLES(S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_n(in_seg),
        .an_n(in_an),
        .bcd_out(bcd_out),
        .digit_err(digit_err),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    bit chk_en = 0;

    logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100};

    // Reference model: synchroniser as a 2-deep delay line, stability as the
    // length of the current run of identical (digit, pattern) observations.
    logic [6:0]   q_seg [2];
    logic [N-1:0] q_an  [2];
    logic [6:0]   p_seg;
    int           p_idx;
    bit           p_valid;
    int           run;
    logic [3:0]   sh [N];
    bit           sh_err [N];
    int           seen;
    logic [4*N-1:0] m_bcd;
    logic [N-1:0] m_derr;
    bit           m_fv;
    int           tmo;

    function automatic int mdec(input logic [6:0] s, output bit e);
        e = 0;
        for (int k = 0; k < 10; k++) if (pats[k] == s) return k;
        if (s == 7'h7F) return 15;
        e = 1;
        return 14;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin q_seg[k] = '1; q_an[k] = '1; end
        p_seg = '1; p_idx = 0; p_valid = 0; run = 0;
        for (int k = 0; k < N; k++) begin sh[k] = 4'hF; sh_err[k] = 0; end
        seen = 0; m_bcd = '1; m_derr = '0; m_fv = 0; tmo = 0;
    endtask

    task automatic model_step();
        logic [6:0] cs;
        logic [N-1:0] ca;
        int nz, idx, code;
        bit valid, cap, e;
        cs = q_seg[1]; ca = q_an[1];
        nz = 0; idx = 0;
        for (int k = 0; k < N; k++) if (!ca[k]) begin nz++; idx = k; end
        valid = (nz == 1);
        if (valid) run = (p_valid && idx == p_idx && cs == p_seg) ? ((run < 1000) ? run + 1 : run) : 1;
        else run = 0;
        cap = valid && (run == S);
        p_valid = valid; p_idx = idx; p_seg = cs;
        if (seen == (1 << N) - 1) begin
            for (int k = 0; k < N; k++) begin
                m_bcd[4*k +: 4] = sh[k];
                m_derr[k] = sh_err[k];
            end
            m_fv = 1; seen = 0;
        end else m_fv = 0;
        if (cap) begin
            code = mdec(cs, e);
            sh[idx] = code[3:0]; sh_err[idx] = e;
            seen = seen | (1 << idx);
        end
        tmo = cap ? 0 : ((tmo < T) ? tmo + 1 : T);
        q_seg[1] = q_seg[0]; q_an[1] = q_an[0];
        q_seg[0] = in_seg;   q_an[0] = in_an;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("bcd_out", 32'(bcd_out), 32'(m_bcd));
            cmp("digit_err", 32'(digit_err), 32'(m_derr));
            cmp("frame_valid", 32'(frame_valid), 32'(m_fv));
            cmp("frame_err", 32'(frame_err), 32'(|m_derr));
            cmp("stale", 32'(stale), 32'(tmo == T));
            if (frame_valid === 1'b1) fv_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] p, input int cyc);
        in_an = ~(N'(1) << d);
        in_seg = p;
        repeat (cyc) tick();
    endtask

    task automatic idle(input int cyc);
        in_an = '1;
        repeat (cyc) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    int base;
    int c;

    initial begin
        model_reset();
        #1;
        rst = 1'b1;
        chk_en = 1;
        repeat (2) tick();
        rst = 1'b0;
        cmp("reset_bcd", 32'(bcd_out), 32'hFFFF);
        cmp("reset_stale", 32'(stale), 32'h0);

        // Scan 1,2,3,4
        base = fv_count;
        show(0, pats[1], 20); show(1, pats[2], 20);
        show(2, pats[3], 20); show(3, pats[4], 20);
        idle(5);
        cmp("scan_bcd", 32'(bcd_out), 32'h4321);
        cmp("scan_err", 32'({frame_err, digit_err}), 32'h0);
        cmp("scan_pulses", 32'(fv_count - base), 32'd1);

        // Glitch-free replacement: 0 shown too briefly, then 8
        base = fv_count;
        show(0, pats[0], 5); show(0, pats[8], 20);
        show(1, pats[1], 20); show(2, pats[2], 20); show(3, pats[3], 20);
        idle(5);
        cmp("toggle_bcd", 32'(bcd_out), 32'h3218);
        cmp("toggle_pulses", 32'(fv_count - base), 32'd1);

        // Invalid pattern on digit 2
        show(0, pats[0], 20); show(1, pats[0], 20);
        show(2, 7'b0110110, 20); show(3, pats[9], 20);
        idle(5);
        cmp("err_bcd", 32'(bcd_out), 32'h9E00);
        cmp("err_derr", 32'(digit_err), 32'b0100);
        cmp("err_ferr", 32'(frame_err), 32'h1);

        // Multiple anodes low: no capture
        base = fv_count;
        in_an = 4'b1100; in_seg = pats[3];
        repeat (50) tick();
        idle(10);
        cmp("multi_pulses", 32'(fv_count - base), 32'd0);

        // Blank digit decodes to F without error
        show(0, pats[5], 20); show(1, 7'h7F, 20);
        show(2, pats[7], 20); show(3, pats[9], 20);
        idle(5);
        cmp("blank_bcd", 32'(bcd_out), 32'h97F5);
        cmp("blank_err", 32'(frame_err), 32'h0);

        // Staleness timing
        in_an = '1;
        do_reset();
        c = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (stale === 1'b1) begin c = k; break; end
        end
        cmp("stale_rise_cycle", 32'(c), 32'd64);
        repeat (20) tick();
        cmp("stale_hold", 32'(stale), 32'h1);
        show(0, pats[1], 12);
        cmp("stale_clear", 32'(stale), 32'h0);

        // Reset while digit 3 is settling discards the partial frame
        do_reset();
        show(0, pats[6], 20); show(1, pats[7], 20); show(2, pats[8], 20);
        show(3, pats[9], 5);
        rst = 1'b1;
        model_reset();
        #1;
        cmp("midrst_bcd", 32'(bcd_out), 32'hFFFF);
        cmp("midrst_flags", 32'({frame_valid, frame_err, stale, digit_err}), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        base = fv_count;
        show(3, pats[9], 20);
        idle(5);
        cmp("midrst_nopulse", 32'(fv_count - base), 32'd0);
        show(0, pats[6], 20); show(1, pats[7], 20); show(2, pats[8], 20);
        idle(5);
        cmp("midrst_pulse", 32'(fv_count - base), 32'd1);
        cmp("midrst_bcd2", 32'(bcd_out), 32'h9876);

        // Randomised scanning
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) in_an = N'($urandom);
            else in_an = ~(N'(1) << $urandom_range(0, N - 1));
            r = $urandom_range(0, 9);
            if (r < 5) in_seg = pats[$urandom_range(0, 9)];
            else if (r < 7) in_seg = 7'h7F;
            else in_seg = 7'($urandom);
            repeat ($urandom_range(1, 20)) tick();
        end
        idle(5);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Monitors a multiplexed common-anode seven-segment display bus (active-low segments abcdefg plus active-low per-digit anode enables) and recovers the displayed value as packed BCD. Synchronises the bus, waits for each digit's pattern to be stable, decodes it back to a 4-bit code and assembles complete frames with error and staleness flags. Used as the read-back/checker side of the display path: on-chip self-test, or a capture front-end for an external display.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anode lines), range 1..8
STABLE_CYCLES, 8, consecutive clk cycles a synced pattern must hold before capture, >=2
TIMEOUT_CYCLES, 65536, cycles without any capture before stale asserts, >=2

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
seg_n  input  7  segment lines, bit6=a .. bit0=g, 0=ON; asynchronous to clk
an_n  input  NUM_DIGITS  digit enables, bit i = digit i, 0=selected; asynchronous to clk
bcd_out  output  4*NUM_DIGITS  last complete frame; digit i in bits [4i+3:4i]
digit_err  output  NUM_DIGITS  per-digit invalid-pattern flags for last frame
frame_valid  output  1  one-cycle pulse when bcd_out/digit_err/frame_err update
frame_err  output  1  OR of digit_err for last frame
stale  output  1  no capture for TIMEOUT_CYCLES cycles

Behaviour:
- Reset (async assert, sync-safe deassert by design): synchroniser flops all 1s; FSM to WAIT_SEL; stable counter 0; seen mask 0; shadow regs 4'hF; bcd_out all 4'hF; digit_err 0; frame_valid 0; frame_err 0; stale 0; timeout counter 0.
- Synchronisation: seg_n and an_n each pass through 2 flops; all logic below uses synced values only (2-cycle input latency).
- Selection valid when exactly one bit of synced an_n is 0; index = that bit position. Zero or multiple low bits = no selection.
- FSM:
  - WAIT_SEL: counter 0. Valid selection -> SETTLE (counter=1).
  - SETTLE: if selection invalid -> WAIT_SEL; if selected digit or synced seg differs from previous cycle -> stay SETTLE, counter=1; else counter+1; when counter reaches STABLE_CYCLES -> capture this cycle, go HOLD.
  - HOLD: selection invalid -> WAIT_SEL; digit index or seg changes -> SETTLE, counter=1; else stay (no repeat capture).
- Capture: total latency = 2 sync cycles + STABLE_CYCLES from input edge. Writes decoded code to shadow[i], err flag to shadow_err[i], sets seen[i]. Re-capture of a digit before frame completion overwrites shadow silently.
- Decode (synced seg_n abcdefg -> code): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->4'hF (blank, not an error); any other pattern -> 4'hE with err=1.
- Frame: on the cycle after a capture makes seen all-ones: bcd_out<=shadow, digit_err<=shadow_err, frame_err<=|shadow_err, frame_valid=1 for exactly that cycle, seen<=0. Capture arriving in the same cycle as frame emit counts toward the next frame (its seen bit survives the clear). Outputs hold between frames.
- Timeout: counter increments each cycle, saturates at TIMEOUT_CYCLES; stale=1 while saturated. Any capture clears counter to 0 and stale to 0 the next cycle.
- Reset mid-operation: partial frame discarded; first frame after reset needs every digit captured again.
- Counter widths: stable counter $clog2(STABLE_CYCLES+1) bits, timeout counter $clog2(TIMEOUT_CYCLES+1) bits; no wrap.

Test Plan:
- Scan digits 0..3 showing 1,2,3,4 (patterns 1001111,0010010,0000110,1001100), 20 cycles each, STABLE_CYCLES=8 -> single frame_valid pulse, bcd_out=16'h4321, digit_err=0, frame_err=0.
- Digit 0 pattern 0000001 toggled to 0000000 after 5 synced cycles then held -> capture 8 cycles after toggle, code 8; no capture of 0.
- Digit 2 driven 0110110, others 0,0,9 -> bcd_out=16'h9E00 (digit3=9), digit_err=4'b0100, frame_err=1.
- an_n=4'b1100 held 50 cycles, then 4'b1111 -> no capture, seen unchanged, no frame_valid; blank pattern 1111111 on a valid digit -> nibble F, no error.
- TIMEOUT_CYCLES=64, no selection after reset -> stale rises at cycle 64, stays high; one capture -> stale low next cycle.
- Assert rst during SETTLE of digit 3 after digits 0..2 captured -> outputs at reset values immediately; full 4-digit rescan required before next frame_valid.
